ly_edge_tagger: RTL and testbench

- Inverse of the layer one-shot stretcher: takes per-bit stretched layer hits, which may be held high for several clocks, and turns each rising edge into a single-clock registered pulse.
- Measures how long each bit stays high and raises a sticky stuck flag on any bit held high too long; stuck bits are masked from edge output.
- Provides a registered per-cycle count of edge pulses for the hit-multiplicity and trigger logic downstream of the pattern finder.

---
 rtl/ly_edge_tagger.sv | 87 ++++++++
 tb/tb_ly_edge_tagger.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ly_edge_tagger.sv
// Leading-edge tagger for stretched layer hits: one-clock edge pulses, per-bit
// high-run watchdog with sticky stuck flags, and a registered edge popcount.
module ly_edge_tagger #(
  parameter int unsigned WIDTH       = 224,
  parameter int unsigned RUNW        = 5,
  parameter int unsigned STUCK_LIMIT = 24,
  parameter int unsigned CNTW        = 8
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             clear_stuck_i,
  output logic [WIDTH-1:0] edge_o,
  output logic [WIDTH-1:0] stuck_o,
  output logic [CNTW-1:0]  nedges_o,
  output logic             any_stuck_o
);

  localparam int unsigned CNT_MAX = (1 << CNTW) - 1;

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] stuck_q, stuck_d;
  logic [RUNW-1:0]  run_q [WIDTH];
  logic [RUNW-1:0]  run_d [WIDTH];
  logic [CNTW-1:0]  nedges_q, nedges_d;
  logic             any_stuck_q, any_stuck_d;
  int unsigned      cnt;

  always_comb begin
    prev_d = in_i;
    // Masking uses the registered flag; a fresh rise always has run=0, so the
    // clock that sets stuck can never also carry an edge.
    edge_d = in_i & ~prev_q & ~stuck_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      run_d[i]   = run_q[i];
      stuck_d[i] = stuck_q[i];
      if (!in_i[i]) begin
        run_d[i] = '0;
      end else if (clear_stuck_i) begin
        run_d[i] = '0;
      end else if (run_q[i] != '1) begin
        run_d[i] = run_q[i] + RUNW'(1);
      end
      if (clear_stuck_i) begin
        stuck_d[i] = 1'b0;
      end else if (in_i[i] && (run_q[i] == RUNW'(STUCK_LIMIT - 1))) begin
        stuck_d[i] = 1'b1;
      end
    end

    cnt = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt = cnt + 32'(edge_q[i]);
    end
    nedges_d    = (cnt > CNT_MAX) ? '1 : CNTW'(cnt);
    any_stuck_d = |stuck_q;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prev_q      <= '0;
      edge_q      <= '0;
      stuck_q     <= '0;
      nedges_q    <= '0;
      any_stuck_q <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        run_q[i] <= '0;
      end
    end else begin
      prev_q      <= prev_d;
      edge_q      <= edge_d;
      stuck_q     <= stuck_d;
      nedges_q    <= nedges_d;
      any_stuck_q <= any_stuck_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        run_q[i] <= run_d[i];
      end
    end
  end

  assign edge_o      = edge_q;
  assign stuck_o     = stuck_q;
  assign nedges_o    = nedges_q;
  assign any_stuck_o = any_stuck_q;

endmodule

// File: tb/tb_ly_edge_tagger.sv
// Directed bench for ly_edge_tagger with hand-computed expectations.
module tb_ly_edge_tagger;

  localparam int W = 224;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in_v;
  logic         clear;
  logic [W-1:0] edge_v;
  logic [W-1:0] stuck_v;
  logic [7:0]   nedges_v;
  logic         any_stuck_v;

  int n_cmp;
  int n_err;

  ly_edge_tagger #(
    .WIDTH(224),
    .RUNW(5),
    .STUCK_LIMIT(24),
    .CNTW(8)
  ) dut (
    .clock_i      (clk),
    .reset_n_i    (reset_n),
    .in_i         (in_v),
    .clear_stuck_i(clear),
    .edge_o       (edge_v),
    .stuck_o      (stuck_v),
    .nedges_o     (nedges_v),
    .any_stuck_o  (any_stuck_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] bitv(input int idx);
    logic [W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_v    = '0;
    clear   = 1'b0;
    repeat (3) step();
    n_cmp++; if (edge_v !== '0) begin n_err++; $display("FAIL reset_edge: got %h want 0", edge_v); end
    n_cmp++; if (stuck_v !== '0) begin n_err++; $display("FAIL reset_stuck: got %h want 0", stuck_v); end
    n_cmp++; if (nedges_v !== 8'd0) begin n_err++; $display("FAIL reset_nedges: got %0d want 0", nedges_v); end
    n_cmp++; if (any_stuck_v !== 1'b0) begin n_err++; $display("FAIL reset_any_stuck: got %b want 0", any_stuck_v); end
    reset_n = 1'b1;
    step();
    n_cmp++; if (edge_v !== '0) begin n_err++; $display("FAIL reset_release_edge: got %h want 0", edge_v); end
  endtask

  task automatic test_single();
    in_v = bitv(5);
    step();
    n_cmp++; if (edge_v !== bitv(5)) begin n_err++; $display("FAIL single_edge: got %h want %h", edge_v, bitv(5)); end
    n_cmp++; if (nedges_v !== 8'd0) begin n_err++; $display("FAIL single_nedges0: got %0d want 0", nedges_v); end
    step();
    n_cmp++; if (edge_v !== '0) begin n_err++; $display("FAIL single_edge_width: got %h want 0", edge_v); end
    n_cmp++; if (nedges_v !== 8'd1) begin n_err++; $display("FAIL single_nedges1: got %0d want 1", nedges_v); end
    step();
    in_v = '0;
    n_cmp++; if (nedges_v !== 8'd0) begin n_err++; $display("FAIL single_nedges_back: got %0d want 0", nedges_v); end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] three;
    three = bitv(0) | bitv(100) | bitv(223);
    in_v = three;
    step();
    n_cmp++; if (edge_v !== three) begin n_err++; $display("FAIL b2b_edge_first: got %h want %h", edge_v, three); end
    in_v[100] = 1'b0;
    step();
    n_cmp++; if (edge_v !== '0) begin n_err++; $display("FAIL b2b_edge_gap: got %h want 0", edge_v); end
    n_cmp++; if (nedges_v !== 8'd3) begin n_err++; $display("FAIL b2b_nedges3: got %0d want 3", nedges_v); end
    in_v[100] = 1'b1;
    step();
    n_cmp++; if (edge_v !== bitv(100)) begin n_err++; $display("FAIL b2b_edge_second: got %h want %h", edge_v, bitv(100)); end
    n_cmp++; if (nedges_v !== 8'd0) begin n_err++; $display("FAIL b2b_nedges_gap: got %0d want 0", nedges_v); end
    step();
    n_cmp++; if (nedges_v !== 8'd1) begin n_err++; $display("FAIL b2b_nedges1: got %0d want 1", nedges_v); end
    in_v = '0;
    step();
    step();
  endtask

  task automatic test_stuck();
    in_v = bitv(7);
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) begin
        n_cmp++; if (edge_v !== bitv(7)) begin n_err++; $display("FAIL stuck_first_edge: got %h want %h", edge_v, bitv(7)); end
      end
      if (k == 23) begin
        n_cmp++; if (stuck_v !== '0) begin n_err++; $display("FAIL stuck_early: got %h want 0", stuck_v); end
      end
      if (k == 24) begin
        n_cmp++; if (stuck_v !== bitv(7)) begin n_err++; $display("FAIL stuck_set: got %h want %h", stuck_v, bitv(7)); end
        n_cmp++; if (any_stuck_v !== 1'b0) begin n_err++; $display("FAIL any_stuck_lag: got %b want 0", any_stuck_v); end
      end
      if (k == 25) begin
        n_cmp++; if (any_stuck_v !== 1'b1) begin n_err++; $display("FAIL any_stuck_set: got %b want 1", any_stuck_v); end
      end
    end
    in_v = '0;
    step();
    n_cmp++; if (stuck_v !== bitv(7)) begin n_err++; $display("FAIL stuck_sticky_low: got %h want %h", stuck_v, bitv(7)); end
    in_v = bitv(7);
    step();
    n_cmp++; if (edge_v !== '0) begin n_err++; $display("FAIL stuck_masked_edge: got %h want 0", edge_v); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (stuck_v !== '0) begin n_err++; $display("FAIL stuck_cleared: got %h want 0", stuck_v); end
    n_cmp++; if (edge_v !== '0) begin n_err++; $display("FAIL stuck_clear_no_edge: got %h want 0", edge_v); end
    in_v = '0;
    step();
    in_v = bitv(7);
    step();
    n_cmp++; if (edge_v !== bitv(7)) begin n_err++; $display("FAIL stuck_edge_after_clear: got %h want %h", edge_v, bitv(7)); end
    in_v = '0;
    step();
    step();
    n_cmp++; if (any_stuck_v !== 1'b0) begin n_err++; $display("FAIL any_stuck_cleared: got %b want 0", any_stuck_v); end
  endtask

  task automatic test_clear_collision();
    in_v = bitv(9);
    repeat (23) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (stuck_v !== '0) begin n_err++; $display("FAIL collide_clear_wins: got %h want 0", stuck_v); end
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 23) begin
        n_cmp++; if (stuck_v !== '0) begin n_err++; $display("FAIL collide_restart_early: got %h want 0", stuck_v); end
      end
      if (k == 24) begin
        n_cmp++; if (stuck_v !== bitv(9)) begin n_err++; $display("FAIL collide_reflag: got %h want %h", stuck_v, bitv(9)); end
      end
    end
    in_v  = '0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (stuck_v !== '0) begin n_err++; $display("FAIL collide_clear_low: got %h want 0", stuck_v); end
    step();
    step();
  endtask

  task automatic test_all_bits();
    in_v = '1;
    step();
    n_cmp++; if (edge_v !== {W{1'b1}}) begin n_err++; $display("FAIL all_edge: got %h want all ones", edge_v); end
    step();
    n_cmp++; if (nedges_v !== 8'd224) begin n_err++; $display("FAIL all_nedges: got %0d want 224", nedges_v); end
    n_cmp++; if (edge_v !== '0) begin n_err++; $display("FAIL all_edge_width: got %h want 0", edge_v); end
    in_v = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    in_v = bitv(12);
    repeat (10) step();
    in_v[13] = 1'b1;
    step();
    n_cmp++; if (edge_v !== bitv(13)) begin n_err++; $display("FAIL mid_pre_edge: got %h want %h", edge_v, bitv(13)); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (edge_v !== '0) begin n_err++; $display("FAIL mid_async_edge: got %h want 0", edge_v); end
    n_cmp++; if (nedges_v !== 8'd0) begin n_err++; $display("FAIL mid_async_nedges: got %0d want 0", nedges_v); end
    @(posedge clk);
    #1;
    in_v[13] = 1'b0;
    reset_n  = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 1) begin
        n_cmp++; if (edge_v !== bitv(12)) begin n_err++; $display("FAIL mid_release_edge: got %h want %h", edge_v, bitv(12)); end
      end
      if (k == 23) begin
        n_cmp++; if (stuck_v !== '0) begin n_err++; $display("FAIL mid_run_restart: got %h want 0", stuck_v); end
      end
      if (k == 24) begin
        n_cmp++; if (stuck_v !== bitv(12)) begin n_err++; $display("FAIL mid_reflag: got %h want %h", stuck_v, bitv(12)); end
      end
    end
    in_v  = '0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    in_v    = '0;
    clear   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stuck();
    test_clear_collision();
    test_all_bits();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
